// File: rtl/axi_wr_burst_feeder.sv
// Show-ahead stream FIFO feeding the AXI write controller one burst request at a time with per-frame wrapped DDR addresses.
// Head word appears one cycle after a push into an empty FIFO; S_READY drops at full and overflowing words are dropped and flagged.
module axi_wr_burst_feeder #(
  parameter int          DATA_WIDTH  = 16,
  parameter int          ADDR_WIDTH  = 28,
  parameter int          BURST_LEN   = 16,
  parameter int          FIFO_DEPTH  = 64,
  parameter int          FRAME_WORDS = 786432,
  parameter int unsigned BASE_ADDR   = 0
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESET,
  input  logic [DATA_WIDTH-1:0]         S_DATA,
  input  logic                          S_VALID,
  input  logic                          S_SOF,
  output logic                          S_READY,
  output logic [DATA_WIDTH-1:0]         FIFO_AXI_DATA,
  input  logic                          FIFO_RD_EN,
  output logic                          WR_REQ,
  input  logic                          WR_ACK,
  input  logic                          WR_DONE,
  output logic [ADDR_WIDTH-1:0]         CTRL_AWADDR,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
  output logic                          FRAME_DONE,
  output logic [2:0]                    ERR_FLAGS
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PW    = AW + 1;
  localparam int OW    = $clog2(FRAME_WORDS);
  localparam int BYTES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_BUSY, ST_ADV} state_t;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_dout;
  logic [OW-1:0]         r_offset;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic                  r_frame_done;
  logic [2:0]            r_err;
  state_t                r_state;

  state_t                w_state_nxt;
  logic                  w_wr_req;
  logic                  w_adv;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic [PW-1:0]         w_level;
  logic [PW-1:0]         w_rd_ptr_nxt;
  logic                  w_sof_ok;
  logic [OW:0]           w_sum;
  logic                  w_wrap;
  logic [OW-1:0]         w_offset_nxt;
  logic [ADDR_WIDTH-1:0] w_awaddr_nxt;

  assign w_empty      = (r_wr_ptr == r_rd_ptr);
  assign w_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_level      = r_wr_ptr - r_rd_ptr;
  assign w_push       = S_VALID && !w_full;
  assign w_pop        = FIFO_RD_EN && !w_empty;
  assign w_rd_ptr_nxt = r_rd_ptr + PW'(w_pop);

  // Frame restart is only legal when nothing of the previous frame is still buffered or in flight.
  assign w_sof_ok     = w_push && S_SOF && (r_state == ST_IDLE) && w_empty;

  assign w_sum        = {1'b0, r_offset} + (OW+1)'(BURST_LEN);
  assign w_wrap       = (w_sum == (OW+1)'(FRAME_WORDS));

  always_comb begin
    w_offset_nxt = r_offset;
    if (w_sof_ok) begin
      w_offset_nxt = '0;
    end else if (w_adv) begin
      w_offset_nxt = w_wrap ? '0 : w_sum[OW-1:0];
    end
  end

  assign w_awaddr_nxt = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(w_offset_nxt) * ADDR_WIDTH'(BYTES);

  always_ff @(posedge M_AXI_ACLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= S_DATA;
    end
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_dout   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      r_rd_ptr <= w_rd_ptr_nxt;
      // Head register: bypass the incoming word when it becomes the head, else hold on empty.
      if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
        r_dout <= S_DATA;
      end else if (r_wr_ptr != w_rd_ptr_nxt) begin
        r_dout <= r_mem[w_rd_ptr_nxt[AW-1:0]];
      end
    end
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      r_offset     <= '0;
      r_awaddr     <= ADDR_WIDTH'(BASE_ADDR);
      r_frame_done <= 1'b0;
      r_err        <= '0;
    end else begin
      r_offset     <= w_offset_nxt;
      r_awaddr     <= w_awaddr_nxt;
      r_frame_done <= w_adv && w_wrap;
      r_err[0]     <= r_err[0] | (S_VALID && w_full);
      r_err[1]     <= r_err[1] | (FIFO_RD_EN && w_empty);
      r_err[2]     <= r_err[2] | (w_push && S_SOF && !w_sof_ok);
    end
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr_req    = 1'b0;
    w_adv       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_level >= PW'(BURST_LEN)) begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        w_wr_req = 1'b1;
        if (WR_ACK) begin
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (WR_DONE) begin
          w_state_nxt = ST_ADV;
        end
      end
      ST_ADV: begin
        w_adv       = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign S_READY       = !w_full;
  assign FIFO_AXI_DATA = r_dout;
  assign WR_REQ        = w_wr_req;
  assign CTRL_AWADDR   = r_awaddr;
  assign FIFO_LEVEL    = w_level;
  assign FRAME_DONE    = r_frame_done;
  assign ERR_FLAGS     = r_err;

endmodule

// File: tb/tb_axi_wr_burst_feeder.sv
// Directed bench for axi_wr_burst_feeder: bursts, frame wrap, overflow, underflow, SOF and mid-burst reset.
module tb_axi_wr_burst_feeder;

  localparam int          DW   = 16;
  localparam int          ADW  = 28;
  localparam int          BL   = 16;
  localparam int          FD   = 64;
  localparam int          FW   = 64;
  localparam int unsigned BASE = 32'h100;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [DW-1:0]  s_data = '0;
  logic           s_valid = 1'b0;
  logic           s_sof = 1'b0;
  logic           s_ready;
  logic [DW-1:0]  fifo_data;
  logic           rd_en = 1'b0;
  logic           wr_req;
  logic           wr_ack = 1'b0;
  logic           wr_done = 1'b0;
  logic [ADW-1:0] awaddr;
  logic [6:0]     level;
  logic           frame_done;
  logic [2:0]     err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  axi_wr_burst_feeder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(ADW), .BURST_LEN(BL),
    .FIFO_DEPTH(FD), .FRAME_WORDS(FW), .BASE_ADDR(BASE)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .S_DATA(s_data), .S_VALID(s_valid), .S_SOF(s_sof), .S_READY(s_ready),
    .FIFO_AXI_DATA(fifo_data), .FIFO_RD_EN(rd_en),
    .WR_REQ(wr_req), .WR_ACK(wr_ack), .WR_DONE(wr_done),
    .CTRL_AWADDR(awaddr), .FIFO_LEVEL(level),
    .FRAME_DONE(frame_done), .ERR_FLAGS(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input logic [DW-1:0] d0, input int n);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = d0 + DW'(i);
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic serve_burst(input logic [31:0] exp_addr, input logic [DW-1:0] d0, input logic exp_fd);
    for (int c = 0; c < 20 && !wr_req; c++) tick();
    check("wr_req", 32'(wr_req), 32'd1);
    check("awaddr", 32'(awaddr), exp_addr);
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    check("req_drop", 32'(wr_req), 32'd0);
    for (int j = 0; j < BL; j++) begin
      check("pop_data", 32'(fifo_data), 32'(d0 + DW'(j)));
      rd_en = 1'b1;
      tick();
    end
    rd_en   = 1'b0;
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    tick();
    check("frame_done", 32'(frame_done), 32'(exp_fd));
    tick();
    check("frame_done_clr", 32'(frame_done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    check("rst_ready",  32'(s_ready),    32'd1);
    check("rst_req",    32'(wr_req),     32'd0);
    check("rst_addr",   32'(awaddr),     BASE);
    check("rst_level",  32'(level),      32'd0);
    check("rst_fd",     32'(frame_done), 32'd0);
    check("rst_err",    32'(err),        32'd0);
    check("rst_data",   32'(fifo_data),  32'd0);
    rst = 1'b0;
    tick();

    // First burst: 15 words are not enough, the 16th triggers a request.
    push_words(16'h0001, 15);
    check("lvl15",  32'(level),     32'd15);
    check("head1",  32'(fifo_data), 32'h1);
    tick();
    check("no_req15", 32'(wr_req), 32'd0);
    push_words(16'h0010, 1);
    for (int c = 0; c < 2 && !wr_req; c++) tick();
    check("req_in_2", 32'(wr_req), 32'd1);
    serve_burst(BASE, 16'h0001, 1'b0);
    check("addr_next", 32'(awaddr), BASE + 32);

    // Remaining bursts of the 64-word frame, then wrap to the frame start.
    push_words(16'h0011, 16);
    serve_burst(BASE + 32, 16'h0011, 1'b0);
    push_words(16'h0021, 16);
    serve_burst(BASE + 64, 16'h0021, 1'b0);
    push_words(16'h0031, 16);
    serve_burst(BASE + 96, 16'h0031, 1'b1);
    check("addr_wrap", 32'(awaddr), BASE);
    push_words(16'h0041, 16);
    serve_burst(BASE, 16'h0041, 1'b0);

    // Underflow on an empty FIFO.
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("uf_err",   32'(err),   32'b010);
    check("uf_level", 32'(level), 32'd0);

    // Misplaced SOF with 3 words buffered leaves the address alone.
    push_words(16'h0900, 3);
    s_sof = 1'b1;
    push_words(16'h0903, 1);
    s_sof = 1'b0;
    check("sof_err",   32'(err),    32'b110);
    check("sof_addr",  32'(awaddr), BASE + 32);
    check("sof_level", 32'(level),  32'd4);
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    rd_en = 1'b0;
    check("drain_lvl", 32'(level), 32'd0);

    // Legal SOF on an idle empty FIFO restarts the frame at offset 0.
    s_sof = 1'b1;
    push_words(16'h0A00, 1);
    s_sof = 1'b0;
    check("sof_ok_addr", 32'(awaddr), BASE);
    check("sof_ok_err",  32'(err),    32'b110);
    push_words(16'h0A01, 15);
    serve_burst(BASE, 16'h0A00, 1'b0);

    // Overflow: 65 words with no pops.
    for (int i = 0; i < 65; i++) begin
      s_valid = 1'b1;
      s_data  = 16'h0100 + DW'(i);
      if (i == 64) begin
        check("full_ready", 32'(s_ready), 32'd0);
        check("full_level", 32'(level),   32'd64);
      end
      tick();
    end
    check("of_err",   32'(err),   32'b111);
    check("of_level", 32'(level), 32'd64);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("of_pop_lvl",  32'(level),     32'd63);
    check("of_pop_head", 32'(fifo_data), 32'h0101);
    tick();
    check("of_refill", 32'(level), 32'd64);
    s_valid = 1'b0;

    // Reset in the middle of a burst after 5 beats.
    check("mid_req", 32'(wr_req), 32'd1);
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    for (int j = 0; j < 5; j++) begin
      check("mid_pop", 32'(fifo_data), 32'(16'h0101 + DW'(j)));
      rd_en = 1'b1;
      tick();
    end
    rd_en = 1'b0;
    check("mid_level", 32'(level), 32'd59);
    rst = 1'b1;
    tick();
    check("mrst_req",   32'(wr_req),    32'd0);
    check("mrst_level", 32'(level),     32'd0);
    check("mrst_err",   32'(err),       32'd0);
    check("mrst_addr",  32'(awaddr),    BASE);
    check("mrst_ready", 32'(s_ready),   32'd1);
    check("mrst_data",  32'(fifo_data), 32'd0);
    rst = 1'b0;
    tick();
    push_words(16'h0B00, 16);
    serve_burst(BASE, 16'h0B00, 1'b0);
    check("end_addr", 32'(awaddr), BASE + 32);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_wr_burst_feeder.md
Name: axi_wr_burst_feeder

Overview:
- Upstream stage of the AXI write controller. Buffers an incoming pixel/sample stream in a show-ahead FIFO.
- Issues one burst request at a time, with a DDR word address, once a full burst of data is buffered.
- The write controller pops the FIFO on every accepted W beat.
- Generates the CTRL_AWADDR / FIFO_AXI_DATA pair the controller consumes, and wraps addresses per frame.

Parameters:
DATA_WIDTH, 16, stream and FIFO word width (bits); must equal the controller's AXI data width
ADDR_WIDTH, 28, byte address width of CTRL_AWADDR
BURST_LEN, 16, beats per burst; power of two, 1..256
FIFO_DEPTH, 64, FIFO words; power of two, at least 2*BURST_LEN
FRAME_WORDS, 786432, words per frame; integer multiple of BURST_LEN
BASE_ADDR, 0, byte offset of the frame buffer inside the DDR window

Ports:
M_AXI_ACLK  in  1  single clock
M_AXI_ARESET  in  1  synchronous reset, active-high
S_DATA  in  DATA_WIDTH  input stream word
S_VALID  in  1  S_DATA valid
S_SOF  in  1  start of frame, qualified by S_VALID&&S_READY
S_READY  out  1  FIFO can accept a word
FIFO_AXI_DATA  out  DATA_WIDTH  FIFO head word (show-ahead)
FIFO_RD_EN  in  1  pop strobe from the write controller (W beat accepted)
WR_REQ  out  1  burst request, held until acknowledged
WR_ACK  in  1  controller accepted the request (AW handshake done)
WR_DONE  in  1  one-cycle pulse on the controller's WLAST beat
CTRL_AWADDR  out  ADDR_WIDTH  byte address of the requested burst
FIFO_LEVEL  out  clog2(FIFO_DEPTH)+1  words stored
FRAME_DONE  out  1  one-cycle pulse when the last burst of a frame completes
ERR_FLAGS  out  3  sticky flags: [0] overflow, [1] underflow, [2] misplaced SOF

Behaviour:
- Reset (M_AXI_ARESET=1 at a clock edge) clears all state. This applies mid-burst as well: the FIFO is emptied and the FSM returns to IDLE.
- Output values during and after reset: S_READY=1, WR_REQ=0, CTRL_AWADDR=BASE_ADDR, FIFO_LEVEL=0, FRAME_DONE=0, ERR_FLAGS=0, FIFO_AXI_DATA=0.
- FIFO is circular, with read and write pointers of clog2(FIFO_DEPTH)+1 bits. Full and empty are decided by the MSB compare.
- Push = S_VALID && S_READY. Pop = FIFO_RD_EN && !empty.
- S_READY = (FIFO_LEVEL != FIFO_DEPTH). It is combinational from the registered level, so when full, a same-cycle pop does not enable a push.
- Simultaneous push and pop leaves the level unchanged.
- Latency: a word written into an empty FIFO appears on FIFO_AXI_DATA on the next cycle.
- FIFO_AXI_DATA always presents the head word; after a pop it shows the next word on the following cycle. When the FIFO is empty it holds its last value.
- S_VALID && !S_READY sets ERR_FLAGS[0]; the word is dropped.
- FIFO_RD_EN while empty sets ERR_FLAGS[1]; pointers are unchanged.
- FSM states:
  - IDLE -> REQ when FIFO_LEVEL >= BURST_LEN.
  - REQ: WR_REQ=1 with CTRL_AWADDR stable. On WR_ACK -> BUSY; WR_REQ drops on the next cycle.
  - BUSY: waits for WR_DONE, then -> ADV.
  - ADV: one cycle. Updates the word offset, then -> IDLE.
- Only one burst is outstanding at a time, so WR_REQ is never reasserted before ADV.
- Address: CTRL_AWADDR = BASE_ADDR + offset*(DATA_WIDTH/8), truncated to ADDR_WIDTH and registered. Offset is a word counter.
- In ADV:
  - If offset + BURST_LEN == FRAME_WORDS: offset <= 0 and FRAME_DONE pulses for one cycle.
  - Otherwise offset <= offset + BURST_LEN.
- SOF handling:
  - An accepted S_SOF while the FSM is in IDLE and the FIFO is empty forces offset to 0 on that cycle. The pushed word is frame word 0.
  - An accepted S_SOF under any other condition sets ERR_FLAGS[2] and the offset is unchanged.
- WR_DONE outside BUSY and WR_ACK outside REQ are ignored.
- ERR_FLAGS clear only on reset.

Test Plan:
- Reset, then push 15 words 0x0001..0x000F (BURST_LEN=16) -> WR_REQ stays 0 and FIFO_LEVEL=15. Push the 16th word -> WR_REQ=1 within 2 cycles with CTRL_AWADDR=BASE_ADDR.
- Ack the request, pop 16 beats with FIFO_RD_EN, pulse WR_DONE -> FIFO_AXI_DATA sequence is 0x0001..0x0010 and the next WR_REQ has CTRL_AWADDR=BASE_ADDR+32.
- FRAME_WORDS=64: stream 64 words and complete 4 bursts -> addresses 0, 32, 64, 96; FRAME_DONE pulses once after the 4th WR_DONE; the 5th burst address is 0.
- Hold FIFO_RD_EN=0 and push 65 words with S_VALID constantly high (FIFO_DEPTH=64) -> S_READY=0 at level 64 and ERR_FLAGS[0]=1. Then one pop with S_VALID held high -> level 64 again two cycles later.
- Pulse FIFO_RD_EN on an empty FIFO -> ERR_FLAGS[1]=1 and FIFO_LEVEL stays 0. Send S_SOF with the FIFO holding 3 words -> ERR_FLAGS[2]=1 and the address is unchanged.
- Assert M_AXI_ARESET during BUSY after 5 pops -> next cycle WR_REQ=0, FIFO_LEVEL=0, ERR_FLAGS=0, CTRL_AWADDR=BASE_ADDR; a fresh 16-word push restarts at offset 0.
